// File: rtl/ipg_mem_if.sv
// Bundled rx chunk, memory request/response and tx reply signals of the IPG memory engine.
interface ipg_mem_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 7,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MAX_BYTES  = 64
);
  localparam int unsigned MEM_W   = 8 * MAX_BYTES;
  localparam int unsigned BYTES_W = $clog2(MAX_BYTES + 1);

  logic [DATA_WIDTH-1:0] rx_data;
  logic [LEN_WIDTH-1:0]  rx_len;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [MEM_W-1:0]      mem_req_wdata;
  logic [BYTES_W-1:0]    mem_req_bytes;
  logic                  mem_rsp_valid;
  logic [MEM_W-1:0]      mem_rsp_rdata;
  logic [63:0]           tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;

  modport master (
    input  rx_data, rx_len, rx_valid, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, tx_ready,
    output rx_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_bytes,
           tx_data, tx_valid, tx_last
  );

  modport slave (
    output rx_data, rx_len, rx_valid, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, tx_ready,
    input  rx_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_bytes,
           tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/ipg_mem_engine.sv
// Parses MSB-aligned IPG bit chunks into header/address/write-data, issues memory requests
// and streams read replies back as 64b control blocks.
module ipg_mem_engine #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 7,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MAX_BYTES  = 64,
  parameter logic [7:0]  BLOCK_TYPE = 8'h1e
) (
  input  logic       clk,
  input  logic       reset,
  ipg_mem_if.master  bus,
  output logic       err_pulse,
  output logic       busy
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned MW    = 8 * MAX_BYTES;
  localparam int unsigned BW    = $clog2(MAX_BYTES + 1);
  localparam int unsigned FMAX0 = (MW > ADDR_WIDTH) ? MW : ADDR_WIDTH;
  localparam int unsigned FMAX  = (FMAX0 > DW) ? FMAX0 : DW;
  localparam int unsigned CW    = $clog2(FMAX + 1);
  localparam int unsigned RW    = 16 + MW;
  localparam int unsigned NCH   = (RW + 55) / 56;
  localparam int unsigned TW    = 56 * NCH;
  localparam int unsigned RCW   = $clog2(TW + 56);
  localparam int unsigned TCW   = $clog2(NCH + 1);

  typedef enum logic [2:0] {S_HDR, S_ADDR, S_WDATA, S_MREQ, S_MWAIT, S_TX} state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         held_data_q, held_data_d;
  logic [LEN_WIDTH-1:0]  held_cnt_q, held_cnt_d;
  logic [CW-1:0]         field_cnt_q, field_cnt_d;
  logic [15:0]           hdr_q, hdr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MW-1:0]         wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [BW-1:0]         len_q, len_d;
  logic [13:0]           hdr_len_q, hdr_len_d;
  logic [TW-1:0]         reply_q, reply_d;
  logic [TCW-1:0]        tx_left_q, tx_left_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mreq_q, mreq_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic [63:0]           tx_data_q, tx_data_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  collecting, field_done, hdr_bad;
  logic [CW-1:0]         fw, fleft, hcnt, take;
  logic [DW-1:0]         chunk_bits;
  logic [15:0]           hdr_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [MW-1:0]         wdata_nx;
  logic [BW-1:0]         len_eff;
  logic [LEN_WIDTH-1:0]  rx_len_clamp;
  logic [RCW-1:0]        rbits;
  logic [TCW-1:0]        nch;
  logic [TW-1:0]         reply_new, reply_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR;
      held_data_q <= '0;
      held_cnt_q  <= '0;
      field_cnt_q <= '0;
      hdr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      len_q       <= '0;
      hdr_len_q   <= '0;
      reply_q     <= '0;
      tx_left_q   <= '0;
      rx_ready_q  <= 1'b0;
      mreq_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_data_q <= held_data_d;
      held_cnt_q  <= held_cnt_d;
      field_cnt_q <= field_cnt_d;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      len_q       <= len_d;
      hdr_len_q   <= hdr_len_d;
      reply_q     <= reply_d;
      tx_left_q   <= tx_left_d;
      rx_ready_q  <= rx_ready_d;
      mreq_q      <= mreq_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Field extraction: move min(field bits left, held bits) from the top of the held chunk.
  always_comb begin
    collecting = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_WDATA);
    case (state_q)
      S_HDR:   fw = CW'(16);
      S_ADDR:  fw = CW'(ADDR_WIDTH);
      S_WDATA: fw = CW'(len_q) << 3;
      default: fw = '0;
    endcase
    fleft      = fw - field_cnt_q;
    hcnt       = CW'(held_cnt_q);
    take       = collecting ? ((fleft < hcnt) ? fleft : hcnt) : '0;
    field_done = collecting && (take != '0) && ((field_cnt_q + take) == fw);
    chunk_bits = held_data_q >> (CW'(DW) - take);
    hdr_nx     = (hdr_q << take) | 16'(chunk_bits);
    addr_nx    = (addr_q << take) | ADDR_WIDTH'(chunk_bits);
    wdata_nx   = wdata_q | (MW'(chunk_bits) << (CW'(MW) - field_cnt_q - take));
    hdr_bad    = hdr_nx[15] || (hdr_nx[13:0] > 14'(MAX_BYTES));
    len_eff    = (hdr_nx[13:0] == 14'd0) ? BW'(MAX_BYTES) : BW'(hdr_nx[13:0]);
    rx_len_clamp = (bus.rx_len > LEN_WIDTH'(DW)) ? LEN_WIDTH'(DW) : bus.rx_len;
  end

  // Reply image: header, top 8*LEN data bits, all-ones below the reply length.
  always_comb begin
    rbits       = RCW'(16) + (RCW'(len_q) << 3);
    nch         = TCW'((rbits + RCW'(55)) / RCW'(56));
    reply_new   = (TW'({2'b10, hdr_len_q, bus.mem_rsp_rdata}) << (TW - RW)) | ({TW{1'b1}} >> rbits);
    reply_shift = reply_q << 56;
  end

  always_comb begin
    state_d     = state_q;
    held_data_d = held_data_q;
    held_cnt_d  = held_cnt_q;
    field_cnt_d = field_cnt_q;
    hdr_d       = hdr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    len_d       = len_q;
    hdr_len_d   = hdr_len_q;
    reply_d     = reply_q;
    tx_left_d   = tx_left_q;
    tx_last_d   = tx_last_q;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;

    if (take != '0) begin
      held_data_d = held_data_q << take;
      held_cnt_d  = held_cnt_q - LEN_WIDTH'(take);
      field_cnt_d = field_cnt_q + take;
    end
    if (rx_ready_q && bus.rx_valid) begin
      held_data_d = bus.rx_data;
      held_cnt_d  = rx_len_clamp;
    end

    case (state_q)
      S_HDR: begin
        hdr_d = hdr_nx;
        if (field_done) begin
          field_cnt_d = '0;
          if (hdr_bad) begin
            err_d = 1'b1;
          end else begin
            we_d      = hdr_nx[14];
            len_d     = len_eff;
            hdr_len_d = hdr_nx[13:0];
            wdata_d   = '0;
            state_d   = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        addr_d = addr_nx;
        if (field_done) begin
          field_cnt_d = '0;
          state_d     = we_q ? S_WDATA : S_MREQ;
        end
      end
      S_WDATA: begin
        wdata_d = wdata_nx;
        if (field_done) begin
          field_cnt_d = '0;
          state_d     = S_MREQ;
        end
      end
      S_MREQ: begin
        if (mreq_q && bus.mem_req_ready) state_d = we_q ? S_HDR : S_MWAIT;
      end
      S_MWAIT: begin
        if (bus.mem_rsp_valid) begin
          reply_d   = reply_new;
          tx_left_d = nch;
          tx_data_d = {reply_new[TW-1 -: 56], BLOCK_TYPE};
          tx_last_d = (nch == TCW'(1));
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (tx_last_q) begin
            tx_data_d = '0;
            tx_last_d = 1'b0;
            state_d   = S_HDR;
          end else begin
            reply_d   = reply_shift;
            tx_left_d = tx_left_q - TCW'(1);
            tx_data_d = {reply_shift[TW-1 -: 56], BLOCK_TYPE};
            tx_last_d = (tx_left_q == TCW'(2));
          end
        end
      end
      default: state_d = S_HDR;
    endcase

    rx_ready_d = (held_cnt_d == '0) && (state_d inside {S_HDR, S_ADDR, S_WDATA});
    mreq_d     = (state_d == S_MREQ);
    tx_valid_d = (state_d == S_TX);
    busy_d     = (state_d != S_HDR) || (held_cnt_d != '0);
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.mem_req_valid = mreq_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_bytes = len_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_last       = tx_last_q;
  assign err_pulse         = err_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_ipg_mem_engine.sv
// Directed scenario bench for ipg_mem_engine with hand-computed expectations.
module tb_ipg_mem_engine;
  logic clk = 1'b0;
  logic reset;
  logic err_pulse, busy;
  int   total = 0;
  int   bad   = 0;

  ipg_mem_if bus ();

  ipg_mem_engine dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_pulse (err_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [63:0] d, input logic [6:0] l, output bit ok);
    ok = 1'b0;
    bus.rx_data = d; bus.rx_len = l; bus.rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rx_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.rx_valid = 1'b0; bus.rx_len = '0; bus.rx_data = '0;
  endtask

  task automatic wait_req(output bit ok, output logic we, output logic [63:0] addr,
                          output logic [511:0] wd, output logic [6:0] bytes);
    ok = 1'b0; we = 1'b0; addr = '0; wd = '0; bytes = '0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mem_req_valid) begin
        ok = 1'b1; we = bus.mem_req_we; addr = bus.mem_req_addr;
        wd = bus.mem_req_wdata; bytes = bus.mem_req_bytes;
        break;
      end
      tick();
    end
    if (ok) begin
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
    end
  endtask

  task automatic rsp_pulse(input logic [511:0] rd);
    bus.mem_rsp_rdata = rd; bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic get_tx(output bit ok, output logic [63:0] d, output logic last);
    ok = 1'b0; d = '0; last = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_valid) begin
        ok = 1'b1; d = bus.tx_data; last = bus.tx_last;
        break;
      end
      tick();
    end
    if (ok) begin
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic start_read(input logic [15:0] hdr, input logic [63:0] addr, output bit ok);
    bit o1, o2;
    send_chunk({hdr, addr[63:16]}, 7'd64, o1);
    send_chunk({addr[15:0], 48'h0}, 7'd16, o2);
    ok = o1 && o2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({bus.rx_ready, bus.mem_req_valid, bus.mem_req_we, bus.tx_valid, bus.tx_last, err_pulse, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {bus.rx_ready, bus.mem_req_valid, bus.mem_req_we, bus.tx_valid, bus.tx_last, err_pulse, busy});
    end
    total++;
    if ((bus.mem_req_addr !== 64'h0) || (bus.mem_req_wdata !== 512'h0) || (bus.mem_req_bytes !== 7'h0) || (bus.tx_data !== 64'h0)) begin
      bad++; $display("FAIL reset_data: addr %h bytes %h tx %h want all 0", bus.mem_req_addr, bus.mem_req_bytes, bus.tx_data);
    end
    reset = 1'b0;
    tick();
    total++;
    if ((bus.rx_ready !== 1'b1) || (busy !== 1'b0)) begin
      bad++; $display("FAIL reset_release: rx_ready %b busy %b want 1 0", bus.rx_ready, busy);
    end
  endtask

  task automatic test_write(input bit bytewise);
    logic [63:0]  addr;
    logic [111:0] v;
    logic [511:0] exp_wd, wd;
    logic [63:0]  got_addr;
    logic [6:0]   bytes;
    logic         we;
    bit           ok, o, sent;
    addr   = 64'hA5A5_0000_1234_5678;
    v      = {16'h4004, addr, 32'hDEADBEEF};
    exp_wd = '0;
    exp_wd[511:480] = 32'hDEADBEEF;
    sent = 1'b1;
    if (!bytewise) begin
      send_chunk(v[111:48], 7'd64, o); sent &= o;
      send_chunk({v[47:0], 16'h0}, 7'd48, o); sent &= o;
    end else begin
      for (int i = 0; i < 14; i++) begin
        send_chunk(64'hFFFF_FFFF_FFFF_FFFF, 7'd0, o); sent &= o;
        send_chunk({v[111-8*i -: 8], 56'h0}, 7'd8, o); sent &= o;
      end
    end
    total++;
    if (!sent) begin bad++; $display("FAIL wr_rx_accept(bytewise=%0d): got timeout want accepted", bytewise); end
    wait_req(ok, we, got_addr, wd, bytes);
    total++;
    if (!ok) begin bad++; $display("FAIL wr_req_seen(bytewise=%0d): got timeout want request", bytewise); end
    total++;
    if ((we !== 1'b1) || (got_addr !== addr) || (bytes !== 7'd4)) begin
      bad++; $display("FAIL wr_req_fields(bytewise=%0d): we %b addr %h bytes %0d want 1 %h 4", bytewise, we, got_addr, bytes, addr);
    end
    total++;
    if (wd !== exp_wd) begin bad++; $display("FAIL wr_wdata(bytewise=%0d): got %h want %h", bytewise, wd, exp_wd); end
    total++;
    if ((busy !== 1'b0) || (bus.rx_ready !== 1'b1) || (bus.mem_req_valid !== 1'b0)) begin
      bad++; $display("FAIL wr_idle(bytewise=%0d): busy %b rx_ready %b req %b want 0 1 0", bytewise, busy, bus.rx_ready, bus.mem_req_valid);
    end
  endtask

  task automatic test_read(input bit stall);
    logic [511:0] rd, wd;
    logic [63:0]  a, d0, d1;
    logic [6:0]   bytes;
    logic         we, l0, l1;
    bit           ok, o0, o1;
    rd = {64'h0123_4567_89AB_CDEF, {14{32'h5A5A_5A5A}}};
    start_read(16'h0008, 64'h1000, ok);
    wait_req(o0, we, a, wd, bytes);
    total++;
    if (!(ok && o0) || (we !== 1'b0) || (a !== 64'h1000) || (bytes !== 7'd8)) begin
      bad++; $display("FAIL rd_req(stall=%0d): ok %0d we %b addr %h bytes %0d want 1 0 1000 8", stall, ok && o0, we, a, bytes);
    end
    rsp_pulse(rd);
    total++;
    if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL rd_latency(stall=%0d): tx_valid %b want 1", stall, bus.tx_valid); end
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if ((bus.tx_valid !== 1'b1) || (bus.tx_data !== 64'h8008_0123_4567_891E) || (bus.rx_ready !== 1'b0)) begin
          bad++; $display("FAIL rd_stall_%0d: valid %b data %h rx_ready %b want 1 8008012345678 91e 0", i, bus.tx_valid, bus.tx_data, bus.rx_ready);
        end
        tick();
      end
    end
    get_tx(o0, d0, l0);
    get_tx(o1, d1, l1);
    total++;
    if (!o0 || (d0 !== 64'h8008_0123_4567_891E) || (l0 !== 1'b0)) begin
      bad++; $display("FAIL rd_chunk0(stall=%0d): got %h last %b want 8008012345678 91e last 0", stall, d0, l0);
    end
    total++;
    if (!o1 || (d1 !== 64'hABCD_EFFF_FFFF_FF1E) || (l1 !== 1'b1)) begin
      bad++; $display("FAIL rd_chunk1(stall=%0d): got %h last %b want abcdefffffffff1e last 1", stall, d1, l1);
    end
    total++;
    if ((bus.tx_valid !== 1'b0) || (bus.rx_ready !== 1'b1)) begin
      bad++; $display("FAIL rd_done(stall=%0d): tx_valid %b rx_ready %b want 0 1", stall, bus.tx_valid, bus.rx_ready);
    end
  endtask

  task automatic test_errors();
    logic [15:0]  hdrs [2];
    logic [511:0] wd;
    logic [63:0]  a, d;
    logic [6:0]   bytes;
    logic         we, l;
    bit           ok, o;
    int           errs, reqs;
    hdrs[0] = 16'hC004;
    hdrs[1] = 16'h0041;
    for (int h = 0; h < 2; h++) begin
      errs = 0; reqs = 0;
      send_chunk({hdrs[h], 48'h0}, 7'd16, ok);
      for (int i = 0; i < 8; i++) begin
        tick();
        if (err_pulse === 1'b1) errs++;
        if (bus.mem_req_valid === 1'b1) reqs++;
      end
      total++;
      if (!ok || (errs != 1) || (reqs != 0)) begin
        bad++; $display("FAIL err_hdr_%h: accepted %0d err cycles %0d reqs %0d want 1 1 0", hdrs[h], ok, errs, reqs);
      end
    end
    start_read(16'h0002, 64'h20, ok);
    wait_req(o, we, a, wd, bytes);
    total++;
    if (!(ok && o) || (we !== 1'b0) || (a !== 64'h20) || (bytes !== 7'd2)) begin
      bad++; $display("FAIL err_then_read_req: ok %0d we %b addr %h bytes %0d want 1 0 20 2", ok && o, we, a, bytes);
    end
    rsp_pulse({16'hBEEF, 496'h0});
    get_tx(o, d, l);
    total++;
    if (!o || (d !== 64'h8002_BEEF_FFFF_FF1E) || (l !== 1'b1)) begin
      bad++; $display("FAIL err_then_read_tx: got %h last %b want 8002beefffffff1e last 1", d, l);
    end
  endtask

  task automatic test_max_len();
    logic [511:0] rd, wd;
    logic [63:0]  a, d, first, lastc;
    logic [6:0]   bytes;
    logic         we, l;
    bit           ok, o;
    int           n;
    for (int i = 0; i < 64; i++) rd[8*i +: 8] = 8'(i);
    start_read(16'h0000, 64'h40, ok);
    wait_req(o, we, a, wd, bytes);
    total++;
    if (!(ok && o) || (we !== 1'b0) || (bytes !== 7'd64)) begin
      bad++; $display("FAIL max_req: ok %0d we %b bytes %0d want 1 0 64", ok && o, we, bytes);
    end
    rsp_pulse(rd);
    n = 0; first = '0; lastc = '0; l = 1'b0;
    while ((n < 12) && !l) begin
      get_tx(o, d, l);
      if (!o) break;
      if (n == 0) first = d;
      lastc = d;
      n++;
    end
    total++;
    if ((n != 10) || (l !== 1'b1)) begin bad++; $display("FAIL max_chunks: got %0d last %b want 10 1", n, l); end
    total++;
    if (first !== 64'h8000_3F3E_3D3C_3B1E) begin bad++; $display("FAIL max_first: got %h want 80003f3e3d3c3b1e", first); end
    total++;
    if (lastc !== 64'h0201_00FF_FFFF_FF1E) begin bad++; $display("FAIL max_last: got %h want 020100ffffffff1e", lastc); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] wd;
    logic [63:0]  a;
    logic [6:0]   bytes;
    logic         we;
    bit           ok, o;
    int           tx_seen;
    start_read(16'h0004, 64'h80, ok);
    wait_req(o, we, a, wd, bytes);
    rsp_pulse({32'h1122_3344, 480'h0});
    total++;
    if (!(ok && o) || (bus.tx_valid !== 1'b1)) begin
      bad++; $display("FAIL mid_reach_tx: ok %0d tx_valid %b want 1 1", ok && o, bus.tx_valid);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({bus.rx_ready, bus.mem_req_valid, bus.mem_req_we, bus.tx_valid, bus.tx_last, err_pulse, busy} !== 7'b0) begin
      bad++; $display("FAIL mid_reset_ctrl: got %b want 0000000",
        {bus.rx_ready, bus.mem_req_valid, bus.mem_req_we, bus.tx_valid, bus.tx_last, err_pulse, busy});
    end
    total++;
    if ((bus.tx_data !== 64'h0) || (bus.mem_req_addr !== 64'h0) || (bus.mem_req_bytes !== 7'h0) || (bus.mem_req_wdata !== 512'h0)) begin
      bad++; $display("FAIL mid_reset_data: tx %h addr %h bytes %h want all 0", bus.tx_data, bus.mem_req_addr, bus.mem_req_bytes);
    end
    reset = 1'b0;
    rsp_pulse({32'h5566_7788, 480'h0});
    tx_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tx_valid === 1'b1) tx_seen++;
      tick();
    end
    total++;
    if ((tx_seen != 0) || (busy !== 1'b0)) begin
      bad++; $display("FAIL mid_stale_rsp: tx cycles %0d busy %b want 0 0", tx_seen, busy);
    end
    test_write(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_data = '0; bus.rx_len = '0; bus.rx_valid = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_write(1'b0);
    test_read(1'b0);
    test_read(1'b1);
    test_write(1'b1);
    test_errors();
    test_max_len();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
